// File: rtl/mem_copy_master_if.sv
// Memory bus between the copy master and the external memory responder.
// Two channels, each ADDR_W address bits and DATA_W data bits. Channel 0
// occupies the low bits of every packed field.
//   Mout_oe_ram        master->slave  read enable per channel
//   Mout_we_ram        master->slave  write enable per channel
//   Mout_addr_ram      master->slave  address per channel
//   Mout_Wdata_ram     master->slave  write data per channel
//   Mout_data_ram_size master->slave  access size in bits, 4-bit field per channel
//   M_Rdata_ram        slave->master  read data per channel
//   M_DataRdy          slave->master  access acknowledge per channel
interface mem_copy_master_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic [1:0]          Mout_oe_ram;
  logic [1:0]          Mout_we_ram;
  logic [2*ADDR_W-1:0] Mout_addr_ram;
  logic [2*DATA_W-1:0] Mout_Wdata_ram;
  logic [7:0]          Mout_data_ram_size;
  logic [2*DATA_W-1:0] M_Rdata_ram;
  logic [1:0]          M_DataRdy;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/mem_copy_master.sv
// Byte-wise block copy master. After an accepted start it copies len bytes
// from src_addr to dst_addr on channel 0 of the memory bus, one read followed
// by one write per byte, strictly forward. Channel 1 is held idle.
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   start_port        start request, honoured only in IDLE
//   src_addr/dst_addr first source / destination byte address (wrap mod 2^ADDR_W)
//   len               number of bytes to copy
//   done_port         one-cycle completion pulse
//   err_port          copy aborted by an access timeout; sticky until next start
//   busy              high from the accepted start through DONE
//   bytes_done        bytes written so far in the current/last copy
//   mem               memory bus, master side
module mem_copy_master #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 9,
  parameter int TIMEOUT = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_port,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               done_port,
  output logic               err_port,
  output logic               busy,
  output logic [LEN_W-1:0]   bytes_done,
  mem_copy_master_if.master  mem
);

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       SIZE_C   = 4'(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  src_q, dst_q, addr_q;
  logic [LEN_W-1:0]   len_q, bytes_q;
  logic [CNT_W-1:0]   wait_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [3:0]         size_q;
  logic               oe_q, we_q, done_q, err_q, busy_q;

  logic [LEN_W-1:0]   bytes_d;
  logic [ADDR_W-1:0]  rd_addr_d, wr_addr_d;
  logic               ack_s;

  // Next byte index and the addresses derived from it (silent wrap).
  always_comb begin
    bytes_d   = bytes_q + {{(LEN_W-1){1'b0}}, 1'b1};
    rd_addr_d = src_q + ADDR_W'(bytes_d);
    wr_addr_d = dst_q + ADDR_W'(bytes_q);
  end

  assign ack_s = mem.M_DataRdy[0];

  // Copy FSM; every output comes straight from a register here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      bytes_q <= '0;
      wait_q  <= '0;
      wdata_q <= '0;
      size_q  <= 4'd0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_port) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= len;
            bytes_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            wait_q  <= '0;
            if (len == '0) begin
              state_q <= S_DONE;
            end else begin
              oe_q    <= 1'b1;
              addr_q  <= src_addr;
              size_q  <= SIZE_C;
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (ack_s) begin
            // oe -> we hand-over: oe is low in the write cycle.
            wdata_q <= mem.M_Rdata_ram[DATA_W-1:0];
            oe_q    <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= wr_addr_d;
            wait_q  <= '0;
            state_q <= S_WR;
          end else if (wait_q == WAIT_MAX) begin
            oe_q    <= 1'b0;
            size_q  <= 4'd0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_q <= wait_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_WR: begin
          if (ack_s) begin
            we_q    <= 1'b0;
            bytes_q <= bytes_d;
            wait_q  <= '0;
            if (bytes_d == len_q) begin
              size_q  <= 4'd0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              oe_q    <= 1'b1;
              addr_q  <= rd_addr_d;
              state_q <= S_RD;
            end
          end else if (wait_q == WAIT_MAX) begin
            we_q    <= 1'b0;
            size_q  <= 4'd0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_q <= wait_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          // Entered with done_q already set after a transfer; a zero-length
          // copy arrives with it clear and spends one extra cycle here.
          if (done_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done_port  = done_q;
  assign err_port   = err_q;
  assign busy       = busy_q;
  assign bytes_done = bytes_q;

  assign mem.Mout_oe_ram        = {1'b0, oe_q};
  assign mem.Mout_we_ram        = {1'b0, we_q};
  assign mem.Mout_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
  assign mem.Mout_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
  assign mem.Mout_data_ram_size = {4'd0, size_q};

endmodule

// File: tb/tb_mem_copy_master.sv
module tb_mem_copy_master;

  localparam int TMO = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_port = 1'b0;
  logic [8:0] src_addr = 9'd0;
  logic [8:0] dst_addr = 9'd0;
  logic [8:0] len = 9'd0;
  logic       done_port, err_port, busy;
  logic [8:0] bytes_done;

  mem_copy_master_if #(.ADDR_W(9), .DATA_W(8)) bus ();

  mem_copy_master #(.ADDR_W(9), .DATA_W(8), .LEN_W(9), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_port (start_port),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .done_port  (done_port),
    .err_port   (err_port),
    .busy       (busy),
    .bytes_done (bytes_done),
    .mem        (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [7:0] mem [512];
  int  rd_dly = 2, wr_dly = 1, stall_read = -1;
  int  rsp_cnt = 0, reads_acked = 0;
  logic [1:0] noise = 2'b00;
  logic rdy0;
  logic oe0, we0;
  logic [8:0] a0;

  assign oe0 = bus.Mout_oe_ram[0];
  assign we0 = bus.Mout_we_ram[0];
  assign a0  = bus.Mout_addr_ram[8:0];

  always_comb begin
    rdy0 = noise[0];
    if (oe0)
      rdy0 = (rsp_cnt == rd_dly - 1) && !(stall_read >= 0 && reads_acked == stall_read);
    else if (we0)
      rdy0 = (rsp_cnt == wr_dly - 1);
  end

  assign bus.M_DataRdy   = {noise[1], rdy0};
  assign bus.M_Rdata_ram = {8'hEE, mem[a0]};

  always @(posedge clock) begin
    noise <= 2'($urandom);
    if ((oe0 || we0) && !rdy0) rsp_cnt <= rsp_cnt + 1;
    else rsp_cnt <= 0;
    if (we0 && rdy0) mem[a0] <= bus.Mout_Wdata_ram[7:0];
    if (start_port) reads_acked <= 0;
    else if (oe0 && rdy0) reads_acked <= reads_acked + 1;
  end

  function automatic logic [63:0] outs();
    return {6'd0, done_port, err_port, busy, bytes_done, bus.Mout_oe_ram, bus.Mout_we_ram,
            bus.Mout_addr_ram, bus.Mout_Wdata_ram, bus.Mout_data_ram_size};
  endfunction

  // Bus invariants every cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("ch1_idle", 64'({bus.Mout_oe_ram[1], bus.Mout_we_ram[1], bus.Mout_addr_ram[17:9],
                           bus.Mout_Wdata_ram[15:8], bus.Mout_data_ram_size[7:4]}), 64'd0);
      chk("oe_we_excl", 64'(oe0 & we0), 64'd0);
      chk("size", 64'(bus.Mout_data_ram_size[3:0]), (oe0 | we0) ? 64'd8 : 64'd0);
    end
  end

  // One copy: reference model is a forward byte loop over an array copy.
  task automatic run_copy(input int s, input int d, input int n, input int dr, input int dw,
                          input int st, input bit poke);
    logic [7:0] ref_m [512];
    int nb, k, exp_k, bad;
    bit seen;
    rd_dly = dr; wr_dly = dw; stall_read = st;
    for (int i = 0; i < 512; i++) ref_m[i] = mem[i];
    nb = (st >= 0 && st < n) ? st : n;
    for (int i = 0; i < nb; i++) ref_m[(d + i) % 512] = ref_m[(s + i) % 512];
    if (n == 0) exp_k = 1;
    else if (nb < n) exp_k = nb * (dr + dw) + TMO;
    else exp_k = n * (dr + dw);

    @(negedge clock);
    start_port = 1'b1; src_addr = 9'(s); dst_addr = 9'(d); len = 9'(n);
    @(posedge clock);
    @(negedge clock);
    start_port = 1'b0;
    chk("err_clr", 64'(err_port), 64'd0);
    chk("busy_set", 64'(busy), 64'd1);
    if (n != 0) chk("oe_first", 64'({oe0, a0}), 64'({1'b1, 9'(s)}));
    else chk("no_oe", 64'({oe0, we0}), 64'd0);
    k = 0; seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done_port) begin seen = 1'b1; break; end
      if (poke && c == 4) begin
        start_port = 1'b1; src_addr = 9'(s + 7); len = 9'd3;
      end
      @(posedge clock);
      k++;
      @(negedge clock);
      start_port = 1'b0;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(k), 64'(exp_k));
    chk("bytes_done", 64'(bytes_done), 64'(nb));
    chk("err_port", 64'(err_port), 64'(nb < n));
    chk("busy_at_done", 64'(busy), 64'd1);
    @(negedge clock);
    chk("done_1cyc", 64'(done_port), 64'd0);
    chk("busy_clr", 64'(busy), 64'd0);
    chk("err_sticky", 64'(err_port), 64'(nb < n));
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_m[i]) bad++;
    chk("mem_image", 64'(bad), 64'd0);
    if (poke) begin
      repeat (10) @(negedge clock);
      chk("no_restart", 64'({busy, oe0, done_port}), 64'd0);
    end
  endtask

  initial begin
    int found;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("reset_idle", outs(), 64'd0);
    end

    // Basic copy, delays 2/1.
    mem[9'h10] = 8'hA1; mem[9'h11] = 8'hB2; mem[9'h12] = 8'hC3; mem[9'h13] = 8'hD4;
    run_copy(9'h10, 9'h40, 4, 2, 1, -1, 1'b0);
    chk("dst_bytes", 64'({mem[9'h40], mem[9'h41], mem[9'h42], mem[9'h43]}), 64'h00000000A1B2C3D4);
    // Zero length.
    run_copy(9'h20, 9'h60, 0, 2, 1, -1, 1'b0);
    // Source wrap with forward overlap.
    run_copy(9'h1FE, 9'h000, 4, 2, 1, -1, 1'b0);
    chk("wrap_overlap", 64'({mem[2], mem[3]}), 64'({mem[0], mem[1]}));
    // Third read never acknowledged, then a clean run clears err_port.
    run_copy(9'h100, 9'h140, 6, 2, 1, 2, 1'b0);
    run_copy(9'h30, 9'h90, 3, 2, 1, -1, 1'b0);
    // Start pulsed while busy is ignored.
    run_copy(9'h50, 9'hA0, 5, 2, 1, -1, 1'b1);

    // Randomized copies.
    for (int t = 0; t < 14; t++) begin
      run_copy(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
               ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1, 1'b0);
    end

    // Reset during the write of byte 1.
    mem[9'h80] = 8'h11; mem[9'h81] = 8'hA5; mem[9'hC0] = 8'h00; mem[9'hC1] = 8'h5A;
    rd_dly = 2; wr_dly = 3; stall_read = -1;
    @(negedge clock);
    start_port = 1'b1; src_addr = 9'h80; dst_addr = 9'hC0; len = 9'd4;
    @(negedge clock);
    start_port = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (we0 && a0 == 9'hC1) begin found = 1; break; end
      @(negedge clock);
    end
    chk("reached_wr1", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_outs", outs(), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst_idle_outs", outs(), 64'd0);
    chk("no_wr1", 64'(mem[9'hC1]), 64'h5A);
    chk("wr0_done", 64'(mem[9'hC0]), 64'h11);

    // Normal operation after the mid-run reset.
    run_copy(9'h80, 9'hC0, 4, 1, 1, -1, 1'b0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
